addsub_acc4b: RTL and testbench
===============================

ADDSUB_ACC4B -- requirements
Module: addsub_acc4b

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the accumulator and operand width in bits; all verification uses WIDTH=4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clear  input  1  synchronous accumulator clear request.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 op  input  1  0 = add, 1 = subtract (acc - operand).
REQ-008 operand  input  WIDTH  operand to add or subtract.
REQ-009 out_valid  output  1  result registered and held.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 acc  output  WIDTH  accumulator value.
REQ-012 carry  output  1  carry-out of the last operation; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  signed two's-complement overflow of the last operation.
REQ-014 op_count  output  4  number of completed operations, wrapping 15 -> 0.

Function
REQ-015 SHALL implement FSM states IDLE, HOLD; in_ready = (state==IDLE) && !clear; out_valid = (state==HOLD).
REQ-016 Accept occurs on a clk edge with in_valid && in_ready; the FSM SHALL go IDLE -> HOLD.
REQ-017 On accept, internal y = operand XOR {WIDTH{op}}; {carry, acc} SHALL load acc + y + op (ripple add-with-inverted-operand form).
REQ-018 On accept, ovf SHALL load (acc[MSB]==y[MSB]) && (sum[MSB]!=acc[MSB]).
REQ-019 Latency: result visible on acc/carry/ovf and out_valid high in the cycle after accept.
REQ-020 In HOLD, acc, carry, ovf SHALL be stable until out_ready is high at a clk edge; then FSM -> IDLE and op_count increments by 1, mod 16.
REQ-021 Only one operation is outstanding; no operand is accepted in HOLD or in the cycle HOLD exits.
REQ-022 Inputs op/operand SHALL be sampled only at accept; changes at other times have no effect.
REQ-023 clear high at a clk edge in any state SHALL set acc=0, carry=0, ovf=0, FSM -> IDLE, discarding any held result without incrementing op_count; op_count is retained.
REQ-024 clear and in_valid together: clear wins, operand not accepted (in_ready low).
REQ-025 clear and out_ready together in HOLD: clear wins, op_count not incremented.
REQ-026 Accumulator wrap-around is modular 2^WIDTH unless the saturation feature (REQ-030) is compiled in.

Reset
REQ-027 On rst high at a clk edge: FSM=IDLE, acc=0, carry=0, ovf=0, op_count=0, out_valid=0; in_ready=1 in the following cycle if clear low.
REQ-028 rst SHALL take priority over clear, accept and out_ready; rst mid-HOLD drops the result.
REQ-029 No output SHALL be X after the first clk edge with rst high.

Configuration
REQ-030 Macro ADDSUB_ACC_SAT_EN: when defined, on signed overflow acc SHALL load the signed limit (0111 if acc was non-negative, 1000 if negative); ovf and carry still report the raw result. When undefined, acc loads the wrapped sum; no extra logic.

Verification
REQ-031 Reset, then accept add 0101 -> next cycle acc=0101, carry=0, ovf=0, out_valid=1; out_ready=1 -> IDLE, op_count=1.
REQ-032 acc=0101, accept subtract 0011 -> acc=0010, carry=1, ovf=0; then subtract 0100 -> acc=1110, carry=0.
REQ-033 acc=0111, accept add 0001 -> ovf=1, acc=1000 without ADDSUB_ACC_SAT_EN, acc=0111 with it.
REQ-034 Hold out_ready=0 for 5 cycles with in_valid=1 and changing operand -> acc stable, in_ready=0, no second accept; release -> exactly one op_count increment.
REQ-035 In HOLD, assert clear and out_ready together -> acc=0, FSM IDLE, op_count unchanged; clear with in_valid in IDLE -> no accept.
REQ-036 Perform 17 completed operations -> op_count=0001 (wrap); assert rst mid-HOLD -> all outputs reset next cycle.

Source files
------------

// File: rtl/addsub_acc4b.sv
// Add/subtract accumulator with a one-deep valid/ready result hold and a completed-operation counter.
// Optional macro ADDSUB_ACC_SAT_EN clamps the accumulator to the signed limit on overflow.
module addsub_acc4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             ovf,
    output logic [3:0]       op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;

    logic             accept;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] acc_next;

`ifdef ADDSUB_ACC_SAT_EN
    // Clamp direction follows the sign of the accumulator before the operation.
    function automatic logic [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] a,
        input logic [WIDTH-1:0]        raw,
        input logic                    overflow
    );
        logic signed [WIDTH-1:0] lim_pos;
        logic signed [WIDTH-1:0] lim_neg;
        lim_pos = {1'b0, {(WIDTH-1){1'b1}}};
        lim_neg = {1'b1, {(WIDTH-1){1'b0}}};
        if (!overflow)
            return raw;
        else if (a < 0)
            return lim_neg;
        else
            return lim_pos;
    endfunction
`endif

    assign in_ready  = (state == IDLE) && !clear;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Subtract is acc + ~operand + 1, so carry=1 means no borrow.
    assign y        = operand ^ {WIDTH{op}};
    assign sum_full = {1'b0, acc} + {1'b0, y} + {{WIDTH{1'b0}}, op};
    assign sum      = sum_full[WIDTH-1:0];
    assign sum_ovf  = (acc[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);

`ifdef ADDSUB_ACC_SAT_EN
    assign acc_next = saturate(acc, sum, sum_ovf);
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
            op_count <= 4'd0;
        end else if (clear) begin
            // Held result is discarded without counting it as completed.
            state <= IDLE;
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= acc_next;
                        carry <= sum_full[WIDTH];
                        ovf   <= sum_ovf;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        op_count <= op_count + 4'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_acc4b.sv
// Directed-vector bench for addsub_acc4b; expectations are hand-computed for WIDTH=4.
module tb_addsub_acc4b;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic       op;
    logic [3:0] operand;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       carry;
    logic       ovf;
    logic [3:0] op_count;

    int checks;
    int failures;

    addsub_acc4b #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .ovf       (ovf),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand for a single cycle; the DUT is expected to be IDLE.
    task automatic offer(input logic o, input logic [3:0] v);
        in_valid = 1'b1;
        op       = o;
        operand  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (acc !== 4'h0) begin failures++; $display("FAIL reset_acc actual=%h required=%h", acc, 4'h0); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry actual=%b required=0", carry); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf actual=%b required=0", ovf); end
        checks++; if (op_count !== 4'h0) begin failures++; $display("FAIL reset_count actual=%h required=0", op_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
    endtask

    task automatic test_add();
        offer(1'b0, 4'b0101);
        checks++; if (acc !== 4'b0101) begin failures++; $display("FAIL add_acc actual=%b required=0101", acc); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL add_carry actual=%b required=0", carry); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL add_ovf actual=%b required=0", ovf); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid actual=%b required=1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready actual=%b required=0", in_ready); end
        release_result();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_release_valid actual=%b required=0", out_valid); end
        checks++; if (op_count !== 4'd1) begin failures++; $display("FAIL add_count actual=%0d required=1", op_count); end
    endtask

    task automatic test_subtract();
        offer(1'b1, 4'b0011);
        checks++; if (acc !== 4'b0010) begin failures++; $display("FAIL sub1_acc actual=%b required=0010", acc); end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL sub1_carry actual=%b required=1", carry); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sub1_ovf actual=%b required=0", ovf); end
        release_result();
        offer(1'b1, 4'b0100);
        checks++; if (acc !== 4'b1110) begin failures++; $display("FAIL sub2_acc actual=%b required=1110", acc); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL sub2_carry actual=%b required=0", carry); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sub2_ovf actual=%b required=0", ovf); end
        release_result();
        checks++; if (op_count !== 4'd3) begin failures++; $display("FAIL sub_count actual=%0d required=3", op_count); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_acc;
`ifdef ADDSUB_ACC_SAT_EN
        exp_acc = 4'b0111;
`else
        exp_acc = 4'b1000;
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (acc !== 4'b0000) begin failures++; $display("FAIL ovf_pre_clear_acc actual=%b required=0000", acc); end
        offer(1'b0, 4'b0111);
        checks++; if (acc !== 4'b0111) begin failures++; $display("FAIL ovf_load7_acc actual=%b required=0111", acc); end
        release_result();
        offer(1'b0, 4'b0001);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag actual=%b required=1", ovf); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL ovf_carry actual=%b required=0", carry); end
        checks++; if (acc !== exp_acc) begin failures++; $display("FAIL ovf_acc actual=%b required=%b", acc, exp_acc); end
        release_result();
        checks++; if (op_count !== 4'd5) begin failures++; $display("FAIL ovf_count actual=%0d required=5", op_count); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (op_count !== 4'd5) begin failures++; $display("FAIL ovf_clear_count actual=%0d required=5", op_count); end
    endtask

    task automatic test_back_to_back();
        offer(1'b0, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = i[0];
            operand  = 4'(i + 9);
            tick();
            checks++; if (acc !== 4'b0011) begin failures++; $display("FAIL hold_acc[%0d] actual=%b required=0011", i, acc); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready[%0d] actual=%b required=0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid[%0d] actual=%b required=1", i, out_valid); end
        end
        in_valid = 1'b0;
        release_result();
        checks++; if (op_count !== 4'd6) begin failures++; $display("FAIL hold_count actual=%0d required=6", op_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid actual=%b required=0", out_valid); end
        checks++; if (acc !== 4'b0011) begin failures++; $display("FAIL hold_release_acc actual=%b required=0011", acc); end
        tick();
        checks++; if (op_count !== 4'd6) begin failures++; $display("FAIL hold_single_incr actual=%0d required=6", op_count); end
    endtask

    task automatic test_clear();
        offer(1'b0, 4'b0010);
        checks++; if (acc !== 4'b0101) begin failures++; $display("FAIL clr_pre_acc actual=%b required=0101", acc); end
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready actual=%b required=0", in_ready); end
        clear     = 1'b0;
        out_ready = 1'b0;
        checks++; if (acc !== 4'b0000) begin failures++; $display("FAIL clr_acc actual=%b required=0000", acc); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_out_valid actual=%b required=0", out_valid); end
        checks++; if (op_count !== 4'd6) begin failures++; $display("FAIL clr_count actual=%0d required=6", op_count); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL clr_carry actual=%b required=0", carry); end
        clear    = 1'b1;
        in_valid = 1'b1;
        op       = 1'b0;
        operand  = 4'b1001;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_noaccept_valid actual=%b required=0", out_valid); end
        checks++; if (acc !== 4'b0000) begin failures++; $display("FAIL clr_noaccept_acc actual=%b required=0000", acc); end
    endtask

    task automatic test_wrap_and_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            offer(1'b0, 4'b0001);
            release_result();
        end
        checks++; if (op_count !== 4'd1) begin failures++; $display("FAIL wrap_count actual=%0d required=1", op_count); end
        checks++; if (acc !== 4'b0001) begin failures++; $display("FAIL wrap_acc actual=%b required=0001", acc); end
        offer(1'b0, 4'b0100);
        checks++; if (acc !== 4'b0101) begin failures++; $display("FAIL rst_pre_acc actual=%b required=0101", acc); end
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        checks++; if (acc !== 4'b0000) begin failures++; $display("FAIL rst_hold_acc actual=%b required=0000", acc); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_hold_valid actual=%b required=0", out_valid); end
        checks++; if (op_count !== 4'd0) begin failures++; $display("FAIL rst_hold_count actual=%0d required=0", op_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_hold_in_ready actual=%b required=1", in_ready); end
        checks++; if ({carry, ovf} !== 2'b00) begin failures++; $display("FAIL rst_hold_flags actual=%b required=00", {carry, ovf}); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        operand   = 4'h0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_subtract();
        test_overflow();
        test_back_to_back();
        test_clear();
        test_wrap_and_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
